// File: rtl/input_port_unit.sv
// ---------------------------------------------------------------------------
// input_port_unit
//
// Requester side of the router's switch-allocation interface. One instance
// sits behind each router input. Incoming flits are buffered in a small FIFO;
// the head flit of each packet is routed XY-style. The resulting destination
// code is handed to the switch allocator. The packet is then streamed onto
// the crossbar while this input holds the grant. The output is released by
// presenting `EMPTY for one strobe cycle.
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active-high
//   in_flit       flit from upstream link
//   in_valid      in_flit valid
//   in_ready      FIFO can accept a flit (simply !full)
//   port_dst      destination code to the switch allocator
//   port_en       port_dst update strobe to the switch allocator
//   grant         crossbar output currently selects this input
//   out_flit      FIFO head, straight to the crossbar
//   out_flit_vld  out_flit is being transferred this cycle
//   drop_cnt      malformed-flit drop count
//
// Optional feature macro: INPUT_PORT_DROP_CNT_EN
//   Defined   -> drop_cnt counts malformed-flit drops, saturating at 8'hFF.
//   Undefined -> drop_cnt is tied to zero; drops still happen.
// ---------------------------------------------------------------------------

`ifndef EMPTY
`define EMPTY          3'd0
`endif
`ifndef OUT_X1_PORT
`define OUT_X1_PORT    3'd1
`endif
`ifndef OUT_X2_PORT
`define OUT_X2_PORT    3'd2
`endif
`ifndef OUT_Y1_PORT
`define OUT_Y1_PORT    3'd3
`endif
`ifndef OUT_LOCAL_PORT
`define OUT_LOCAL_PORT 3'd4
`endif

module input_port_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int X_POS  = 0,
  parameter int Y_POS  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [2:0]        port_dst,
  output logic              port_en,
  input  logic              grant,
  output logic [DATA_W-1:0] out_flit,
  output logic              out_flit_vld,
  output logic [7:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] MY_X = X_POS[1:0];
  localparam logic       MY_Y = Y_POS[0];

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    REL
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state;
  logic [2:0]        r_portDst;
  logic              r_portEn;

  logic [DATA_W-1:0] w_head;
  logic [1:0]        w_type;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_isStart;
  logic              w_isLast;
  logic [2:0]        w_route;
  state_t            w_nextState;
  logic [2:0]        w_nextDst;
  logic              w_nextEn;
  logic              w_flitVld;

  assign w_head    = r_mem[r_rdPtr];
  assign w_type    = w_head[DATA_W-1:DATA_W-2];
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = in_valid && !w_full;
  // Type bit 0 set means head or single (opens a packet); bit 1 set means
  // tail or single (closes a packet).
  assign w_isStart = w_type[0];
  assign w_isLast  = w_type[1];

  assign in_ready     = !w_full;
  assign out_flit     = w_head;
  assign out_flit_vld = w_flitVld;
  assign port_dst     = r_portDst;
  assign port_en      = r_portEn;

  // FIFO storage; no reset needed since the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= in_flit;
    end
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // XY routing on whatever flit is at the FIFO head: X first, then Y.
  always_comb begin
    w_route = `OUT_LOCAL_PORT;
    if (w_head[2:1] > MY_X) begin
      w_route = `OUT_X2_PORT;
    end else if (w_head[2:1] < MY_X) begin
      w_route = `OUT_X1_PORT;
    end else if (w_head[0] != MY_Y) begin
      w_route = `OUT_Y1_PORT;
    end
  end

  // Request/stream/release sequencing. The head flit stays in the FIFO
  // during the request cycle so that it is the first flit streamed once
  // the grant arrives.
  always_comb begin
    w_nextState = r_state;
    w_nextDst   = r_portDst;
    w_nextEn    = 1'b0;
    w_pop       = 1'b0;
    w_flitVld   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          if (w_isStart) begin
            w_nextEn    = 1'b1;
            w_nextDst   = w_route;
            w_nextState = XFER;
          end else begin
            w_pop = 1'b1;
          end
        end
      end
      XFER: begin
        if (grant && !w_empty) begin
          w_pop     = 1'b1;
          w_flitVld = 1'b1;
          if (w_isLast) w_nextState = REL;
        end
      end
      REL: begin
        w_nextEn    = 1'b1;
        w_nextDst   = `EMPTY;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Registered state and switch-allocator outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_portDst <= `EMPTY;
      r_portEn  <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_portDst <= w_nextDst;
      r_portEn  <= w_nextEn;
    end
  end

`ifdef INPUT_PORT_DROP_CNT_EN
  logic [7:0] r_dropCnt;

  // The only pop that happens in IDLE is a malformed-flit drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dropCnt <= 8'd0;
    end else if (w_pop && (r_state == IDLE) && (r_dropCnt != 8'hFF)) begin
      r_dropCnt <= r_dropCnt + 8'd1;
    end
  end

  assign drop_cnt = r_dropCnt;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_input_port_unit.sv
// ---------------------------------------------------------------------------
// tb_input_port_unit
//
// Directed self-checking bench for input_port_unit with X_POS=1, Y_POS=0 and
// DEPTH=4. Inputs change just after the falling edge. Outputs are sampled
// 1 time unit later, well away from the rising edge. Destination codes are
// the values the design uses for `EMPTY and the OUT_*_PORT codes.
// ---------------------------------------------------------------------------
module tb_input_port_unit;

  localparam logic [2:0] C_EMPTY = 3'd0;
  localparam logic [2:0] C_X1    = 3'd1;
  localparam logic [2:0] C_X2    = 3'd2;
  localparam logic [2:0] C_Y1    = 3'd3;
  localparam logic [2:0] C_LOCAL = 3'd4;

`ifdef INPUT_PORT_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP2   = 8'd2;
  localparam logic [7:0] EXP_DROPMAX = 8'hFF;
`else
  localparam logic [7:0] EXP_DROP2   = 8'd0;
  localparam logic [7:0] EXP_DROPMAX = 8'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  port_dst;
  logic        port_en;
  logic        grant = 1'b0;
  logic [31:0] out_flit;
  logic        out_flit_vld;
  logic [7:0]  drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  input_port_unit #(
    .DATA_W(32),
    .DEPTH (4),
    .X_POS (1),
    .Y_POS (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_flit     (in_flit),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .port_dst    (port_dst),
    .port_en     (port_en),
    .grant       (grant),
    .out_flit    (out_flit),
    .out_flit_vld(out_flit_vld),
    .drop_cnt    (drop_cnt)
  );

  // Reset values once rst has been sampled.
  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; grant = 1'b0; in_flit = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (port_dst !== C_EMPTY) begin miscompares++; $display("[TB] FAIL reset_dst got %0d want %0d", port_dst, C_EMPTY); end
    vectors++;
    if (port_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_en got %b want 0", port_en); end
    vectors++;
    if (out_flit_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_vld got %b want 0", out_flit_vld); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rdy got %b want 1", in_ready); end
    vectors++;
    if (drop_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_drop got %0d want 0", drop_cnt); end
    vectors++;
  endtask

  // Head(dst 3,0), body, tail; grant from the cycle after the request.
  task automatic test_single_east;
    logic [31:0] f [3];
    logic        expEn, expVld;
    logic [2:0]  expDst;
    f[0] = 32'h4000_0006; f[1] = 32'h0000_ABCD; f[2] = 32'h8000_1234;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      in_valid = (k < 3);
      in_flit  = (k < 3) ? f[k] : '0;
      grant    = (k >= 3 && k <= 5);
      #1;
      expEn  = (k == 2) || (k == 7);
      expDst = (k >= 2 && k < 7) ? C_X2 : C_EMPTY;
      expVld = (k >= 3 && k <= 5);
      if (port_en !== expEn) begin miscompares++; $display("[TB] FAIL east_en k=%0d got %b want %b", k, port_en, expEn); end
      vectors++;
      if (port_dst !== expDst) begin miscompares++; $display("[TB] FAIL east_dst k=%0d got %0d want %0d", k, port_dst, expDst); end
      vectors++;
      if (out_flit_vld !== expVld) begin miscompares++; $display("[TB] FAIL east_vld k=%0d got %b want %b", k, out_flit_vld, expVld); end
      vectors++;
      if (expVld) begin
        if (out_flit !== f[k-3]) begin miscompares++; $display("[TB] FAIL east_flit k=%0d got %h want %h", k, out_flit, f[k-3]); end
        vectors++;
      end
    end
  endtask

  // Single flits to (0,0), (1,1), (1,0): west, north/south, local.
  task automatic test_routes;
    logic [31:0] f [3];
    logic [2:0]  r [3];
    logic        expEn, expVld;
    logic [2:0]  expDst;
    f[0] = 32'hC000_1000; r[0] = C_X1;
    f[1] = 32'hC000_2003; r[1] = C_Y1;
    f[2] = 32'hC000_3002; r[2] = C_LOCAL;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k <= 6; k++) begin
        @(negedge clk);
        in_valid = (k == 0);
        in_flit  = (k == 0) ? f[p] : '0;
        grant    = (k == 3);
        #1;
        expEn  = (k == 2) || (k == 5);
        expDst = (k >= 2 && k <= 4) ? r[p] : C_EMPTY;
        expVld = (k == 3);
        if (port_en !== expEn) begin miscompares++; $display("[TB] FAIL route%0d_en k=%0d got %b want %b", p, k, port_en, expEn); end
        vectors++;
        if (port_dst !== expDst) begin miscompares++; $display("[TB] FAIL route%0d_dst k=%0d got %0d want %0d", p, k, port_dst, expDst); end
        vectors++;
        if (out_flit_vld !== expVld) begin miscompares++; $display("[TB] FAIL route%0d_vld k=%0d got %b want %b", p, k, out_flit_vld, expVld); end
        vectors++;
        if (expVld) begin
          if (out_flit !== f[p]) begin miscompares++; $display("[TB] FAIL route%0d_flit got %h want %h", p, out_flit, f[p]); end
          vectors++;
        end
      end
    end
  endtask

  // 6-flit packet into a 4-deep FIFO, grant held low then toggled.
  task automatic test_backpressure;
    logic [31:0] f [6];
    int          idx;
    logic        expEn, expVld, expRdy;
    logic [2:0]  expDst;
    f[0] = 32'h4000_0005; f[1] = 32'h0000_0B01; f[2] = 32'h0000_0B02;
    f[3] = 32'h0000_0B03; f[4] = 32'h0000_0B04; f[5] = 32'h8000_0E0E;
    idx = 0;
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      in_valid = (idx < 6);
      in_flit  = (idx < 6) ? f[idx] : '0;
      grant    = (k >= 8 && k <= 18 && (k % 2) == 0);
      #1;
      expRdy = (k < 4) || (k == 9) || (k == 11) || (k >= 13);
      expVld = (k >= 8 && k <= 18 && (k % 2) == 0);
      expEn  = (k == 2) || (k == 20);
      expDst = (k >= 2 && k < 20) ? C_X2 : C_EMPTY;
      if (in_ready !== expRdy) begin miscompares++; $display("[TB] FAIL bp_rdy k=%0d got %b want %b", k, in_ready, expRdy); end
      vectors++;
      if (out_flit_vld !== expVld) begin miscompares++; $display("[TB] FAIL bp_vld k=%0d got %b want %b", k, out_flit_vld, expVld); end
      vectors++;
      if (port_en !== expEn) begin miscompares++; $display("[TB] FAIL bp_en k=%0d got %b want %b", k, port_en, expEn); end
      vectors++;
      if (port_dst !== expDst) begin miscompares++; $display("[TB] FAIL bp_dst k=%0d got %0d want %0d", k, port_dst, expDst); end
      vectors++;
      if (expVld) begin
        if (out_flit !== f[(k-8)/2]) begin miscompares++; $display("[TB] FAIL bp_flit k=%0d got %h want %h", k, out_flit, f[(k-8)/2]); end
        vectors++;
      end
      if (in_valid && in_ready) idx++;
    end
  endtask

  // Body then tail into an empty unit, then a long run of drops.
  task automatic test_malformed;
    int strobes;
    strobes = 0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      in_valid = (k < 2);
      in_flit  = (k == 0) ? 32'h0000_0777 : 32'h8000_0777;
      grant    = 1'b1;
      #1;
      if (port_en !== 1'b0) begin miscompares++; $display("[TB] FAIL mal_en k=%0d got %b want 0", k, port_en); end
      vectors++;
      if (out_flit_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL mal_vld k=%0d got %b want 0", k, out_flit_vld); end
      vectors++;
    end
    if (drop_cnt !== EXP_DROP2) begin miscompares++; $display("[TB] FAIL mal_drop2 got %0d want %0d", drop_cnt, EXP_DROP2); end
    vectors++;
    for (int j = 0; j < 302; j++) begin
      @(negedge clk);
      in_valid = (j < 298);
      in_flit  = 32'h0000_0100 | 32'(j & 8'hFF);
      grant    = 1'b0;
      #1;
      if (port_en || out_flit_vld) strobes++;
    end
    if (strobes !== 0) begin miscompares++; $display("[TB] FAIL mal_strobes got %0d want 0", strobes); end
    vectors++;
    if (drop_cnt !== EXP_DROPMAX) begin miscompares++; $display("[TB] FAIL mal_sat got %0d want %0d", drop_cnt, EXP_DROPMAX); end
    vectors++;
  endtask

  // Reset after the head of a 3-flit packet has popped, then a fresh packet.
  task automatic test_reset_mid;
    logic        expEn, expVld;
    logic [2:0]  expDst;
    logic [31:0] expFlit;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      rst      = (k == 4);
      in_valid = (k < 3) || (k == 9);
      in_flit  = (k == 0) ? 32'h4000_0001 : (k == 1) ? 32'h0000_0222 :
                 (k == 2) ? 32'h8000_0333 : 32'hC000_0042;
      grant    = (k == 3) || (k == 4) || (k == 12);
      #1;
      expEn   = (k == 2) || (k == 11) || (k == 14);
      expDst  = (k >= 2 && k <= 4) ? C_X1 : (k >= 11 && k <= 13) ? C_LOCAL : C_EMPTY;
      expVld  = (k == 3) || (k == 4) || (k == 12);
      expFlit = (k == 3) ? 32'h4000_0001 : (k == 4) ? 32'h0000_0222 : 32'hC000_0042;
      if (port_en !== expEn) begin miscompares++; $display("[TB] FAIL rmid_en k=%0d got %b want %b", k, port_en, expEn); end
      vectors++;
      if (port_dst !== expDst) begin miscompares++; $display("[TB] FAIL rmid_dst k=%0d got %0d want %0d", k, port_dst, expDst); end
      vectors++;
      if (out_flit_vld !== expVld) begin miscompares++; $display("[TB] FAIL rmid_vld k=%0d got %b want %b", k, out_flit_vld, expVld); end
      vectors++;
      if (expVld) begin
        if (out_flit !== expFlit) begin miscompares++; $display("[TB] FAIL rmid_flit k=%0d got %h want %h", k, out_flit, expFlit); end
        vectors++;
      end
      if (k >= 5) begin
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_rdy k=%0d got %b want 1", k, in_ready); end
        vectors++;
      end
    end
  endtask

  // Ten single-flit packets with grant held high across pointer wrap.
  task automatic test_back_to_back;
    int idx, got, req, rel;
    logic [31:0] expFlit;
    idx = 0; got = 0; req = 0; rel = 0;
    for (int k = 0; k < 300 && rel < 10; k++) begin
      @(negedge clk);
      in_valid = (idx < 10);
      in_flit  = 32'hC000_0006 | (32'(idx) << 8);
      grant    = 1'b1;
      #1;
      if (port_en) begin
        if (port_dst !== C_X2 && port_dst !== C_EMPTY) begin miscompares++; $display("[TB] FAIL b2b_dst got %0d want %0d or %0d", port_dst, C_X2, C_EMPTY); end
        vectors++;
        if (port_dst === C_X2) req++;
        if (port_dst === C_EMPTY) rel++;
      end
      if (out_flit_vld) begin
        expFlit = 32'hC000_0006 | (32'(got) << 8);
        if (out_flit !== expFlit) begin miscompares++; $display("[TB] FAIL b2b_flit n=%0d got %h want %h", got, out_flit, expFlit); end
        vectors++;
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    grant = 1'b0; in_valid = 1'b0;
    if (req !== 10) begin miscompares++; $display("[TB] FAIL b2b_req got %0d want 10", req); end
    vectors++;
    if (rel !== 10) begin miscompares++; $display("[TB] FAIL b2b_rel got %0d want 10", rel); end
    vectors++;
    if (got !== 10) begin miscompares++; $display("[TB] FAIL b2b_flits got %0d want 10", got); end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_single_east();
    test_routes();
    test_backpressure();
    test_malformed();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop should the sequence ever stall.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
